// File: rtl/qea_host_pkg.sv
// qea_host_pkg: shared definitions for the QEA host sequencer.
//   state_e   : sequencer FSM states
//   INIT_AMP  : fixed-point 1.0 for the default fraction width
//   init_amp  : fixed-point 1.0 for an arbitrary fraction width
//   job_ok    : accept/reject decision for a job request
//   word_last : index of the last state RAM word (N-1) for a qubit count
package qea_host_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CTX_LOAD,
      ST_STATE_INIT,
      ST_START,
      ST_RUN,
      ST_READ_ISSUE,
      ST_READ_WAIT,
      ST_READ_OUT
   } state_e;

   localparam int          DEF_NUM_FRAC_BIT = 30;
   localparam logic [63:0] INIT_AMP         = 64'd1 << DEF_NUM_FRAC_BIT;

   function automatic logic [63:0] init_amp(input int frac);
      return 64'd1 << frac;
   endfunction

   // A job needs at least one full RAM word of lanes, must fit the state
   // address space, and must carry at least one context word.
   function automatic logic job_ok(input int qbit, input logic ins_nonzero,
                                   input int pe_w, input int addr_w);
      return (qbit >= pe_w) && ((qbit - pe_w) <= addr_w) && ins_nonzero;
   endfunction

   // N-1 where N = 2^(qbit - pe_w); only meaningful for accepted jobs.
   function automatic logic [31:0] word_last(input int qbit, input int pe_w);
      if (qbit < pe_w) return 32'd0;
      return (32'd1 << (qbit - pe_w)) - 32'd1;
   endfunction

endpackage

// File: rtl/qea_host_sequencer_res_reg.sv
// qea_res_reg: single-entry result holding register with valid/ready.
//   load_i/data_i/last_i : capture a new word (only issued while empty)
//   ready_i              : downstream accepts the held word
//   valid_o/data_o/last_o: held word; data and last stay stable while stalled
module qea_res_reg #(
   parameter int WIDTH = 256
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             last_i,
   input  logic             ready_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o,
   output logic             last_o
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             last_q, last_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      last_d  = last_q;
      if (valid_q && ready_i) valid_d = 1'b0;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
         last_d  = last_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign last_o  = last_q;

endmodule

// File: rtl/qea_host_sequencer.sv
// qea_host_sequencer: loads gate context into QEA context RAM, initialises
// QEA state RAM to |0..0>, pulses start, times the run, then streams the
// final state vector out one RAM word at a time.
//   i_run/i_qbit_num/i_ins_num : job request (sampled on i_run)
//   i_ctx_*/o_ctx_ready        : context word stream in
//   o_qea_*                    : QEA start, context RAM and state RAM ports
//   i_qea_complete/i_qea_state_dout : QEA done level and state read data
//   o_res_*/i_res_ready        : result stream out
//   o_busy/o_done/o_err/o_cycle_count : job status
module qea_host_sequencer
   import qea_host_pkg::*;
#(
   parameter int PE_NUM_WIDTH            = 2,
   parameter int PE_NUM                  = 4,
   parameter int DATA_WIDTH              = 32,
   parameter int MAX_QBIT_WIDTH          = 6,
   parameter int STATE_DATA_WIDTH        = DATA_WIDTH*2,
   parameter int STATE_ADDR_WIDTH        = 16,
   parameter int GATE_CONTEXT_DATA_WIDTH = DATA_WIDTH*2,
   parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
   parameter int NUM_FRAC_BIT            = 30
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 i_run,
   input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
   input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_ins_num,
   input  logic                                 i_ctx_valid,
   output logic                                 o_ctx_ready,
   input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_data,
   output logic                                 o_qea_start,
   output logic [MAX_QBIT_WIDTH-1:0]            o_qea_qbit_num,
   output logic                                 o_qea_ctx_en,
   output logic                                 o_qea_ctx_wea,
   output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_qea_ctx_addr,
   output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_qea_ctx_data,
   output logic [PE_NUM-1:0]                    o_qea_state_ena,
   output logic [PE_NUM-1:0]                    o_qea_state_wea,
   output logic [STATE_ADDR_WIDTH-1:0]          o_qea_state_addra,
   output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_qea_state_dina,
   input  logic                                 i_qea_complete,
   input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_qea_state_dout,
   output logic                                 o_res_valid,
   input  logic                                 i_res_ready,
   output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_res_data,
   output logic                                 o_res_last,
   output logic                                 o_busy,
   output logic                                 o_done,
   output logic                                 o_err,
   output logic [31:0]                          o_cycle_count
);

   localparam int WORD_W = PE_NUM*STATE_DATA_WIDTH;
   localparam int CA_W   = GATE_CONTEXT_ADDR_WIDTH;
   localparam int SA_W   = STATE_ADDR_WIDTH;

   // |0..0>: amplitude 1.0 (real part upper half) in the top lane of word 0.
   localparam logic [STATE_DATA_WIDTH-1:0] INIT_LANE =
      {DATA_WIDTH'(init_amp(NUM_FRAC_BIT)), {DATA_WIDTH{1'b0}}};
   localparam logic [WORD_W-1:0] INIT_WORD =
      {INIT_LANE, {(PE_NUM-1)*STATE_DATA_WIDTH{1'b0}}};

   state_e                        state_q, state_d;
   logic [CA_W-1:0]               ctx_idx_q, ctx_idx_d, ins_last_q, ins_last_d;
   logic [SA_W-1:0]               idx_q, idx_d, word_last_q, word_last_d;
   logic                          ctx_ready_q, ctx_ready_d;
   logic                          start_q, start_d;
   logic [MAX_QBIT_WIDTH-1:0]     qbit_q, qbit_d;
   logic                          ctx_en_q, ctx_en_d, ctx_wea_q, ctx_wea_d;
   logic [CA_W-1:0]               ctx_addr_q, ctx_addr_d;
   logic [GATE_CONTEXT_DATA_WIDTH-1:0] ctx_data_q, ctx_data_d;
   logic [PE_NUM-1:0]             st_ena_q, st_ena_d, st_wea_q, st_wea_d;
   logic [SA_W-1:0]               st_addr_q, st_addr_d;
   logic [WORD_W-1:0]             st_dina_q, st_dina_d;
   logic                          busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic [31:0]                   cycle_q, cycle_d;
   logic                          res_load, res_last;

   always_comb begin
      state_d     = state_q;
      ctx_idx_d   = ctx_idx_q;
      ins_last_d  = ins_last_q;
      idx_d       = idx_q;
      word_last_d = word_last_q;
      start_d     = 1'b0;
      qbit_d      = qbit_q;
      ctx_en_d    = 1'b0;
      ctx_wea_d   = 1'b0;
      ctx_addr_d  = ctx_addr_q;
      ctx_data_d  = ctx_data_q;
      st_ena_d    = '0;
      st_wea_d    = '0;
      st_addr_d   = st_addr_q;
      st_dina_d   = st_dina_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      cycle_d     = cycle_q;
      res_load    = 1'b0;
      res_last    = (idx_q == word_last_q);

      unique case (state_q)
         ST_IDLE: begin
            // busy_q is still high during the o_done cycle; a run there is ignored.
            if (i_run && !busy_q) begin
               if (job_ok(int'(i_qbit_num), (i_ins_num != '0), PE_NUM_WIDTH, SA_W)) begin
                  state_d     = ST_CTX_LOAD;
                  qbit_d      = i_qbit_num;
                  ins_last_d  = i_ins_num - CA_W'(1);
                  word_last_d = SA_W'(word_last(int'(i_qbit_num), PE_NUM_WIDTH));
                  ctx_idx_d   = '0;
                  cycle_d     = '0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_CTX_LOAD: begin
            if (i_ctx_valid && ctx_ready_q) begin
               ctx_en_d   = 1'b1;
               ctx_wea_d  = 1'b1;
               ctx_addr_d = ctx_idx_q;
               ctx_data_d = i_ctx_data;
               ctx_idx_d  = ctx_idx_q + CA_W'(1);
               if (ctx_idx_q == ins_last_q) begin
                  state_d = ST_STATE_INIT;
                  idx_d   = '0;
               end
            end
         end
         ST_STATE_INIT: begin
            st_ena_d  = '1;
            st_wea_d  = '1;
            st_addr_d = idx_q;
            st_dina_d = (idx_q == '0) ? INIT_WORD : '0;
            if (idx_q == word_last_q) state_d = ST_START;
            else                      idx_d   = idx_q + SA_W'(1);
         end
         ST_START: begin
            start_d = 1'b1;
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (cycle_q != '1) cycle_d = cycle_q + 32'd1;
            // start_q is high exactly during the first RUN cycle, so it masks
            // a complete level left over from the previous job.
            if (!start_q && i_qea_complete) begin
               state_d   = ST_READ_ISSUE;
               idx_d     = '0;
               st_ena_d  = '1;
               st_addr_d = '0;
            end
         end
         // The read address is registered on entry, so the RAM sees it during
         // READ_ISSUE and dout is valid during READ_WAIT.
         ST_READ_ISSUE: state_d = ST_READ_WAIT;
         ST_READ_WAIT: begin
            res_load = 1'b1;
            state_d  = ST_READ_OUT;
         end
         ST_READ_OUT: begin
            if (o_res_valid && i_res_ready) begin
               if (idx_q == word_last_q) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  idx_d     = idx_q + SA_W'(1);
                  st_ena_d  = '1;
                  st_addr_d = idx_q + SA_W'(1);
                  state_d   = ST_READ_ISSUE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      ctx_ready_d = (state_d == ST_CTX_LOAD);
      busy_d      = (state_d != ST_IDLE) || done_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ctx_idx_q   <= '0;
         ins_last_q  <= '0;
         idx_q       <= '0;
         word_last_q <= '0;
         ctx_ready_q <= 1'b0;
         start_q     <= 1'b0;
         qbit_q      <= '0;
         ctx_en_q    <= 1'b0;
         ctx_wea_q   <= 1'b0;
         ctx_addr_q  <= '0;
         ctx_data_q  <= '0;
         st_ena_q    <= '0;
         st_wea_q    <= '0;
         st_addr_q   <= '0;
         st_dina_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         cycle_q     <= '0;
      end else begin
         state_q     <= state_d;
         ctx_idx_q   <= ctx_idx_d;
         ins_last_q  <= ins_last_d;
         idx_q       <= idx_d;
         word_last_q <= word_last_d;
         ctx_ready_q <= ctx_ready_d;
         start_q     <= start_d;
         qbit_q      <= qbit_d;
         ctx_en_q    <= ctx_en_d;
         ctx_wea_q   <= ctx_wea_d;
         ctx_addr_q  <= ctx_addr_d;
         ctx_data_q  <= ctx_data_d;
         st_ena_q    <= st_ena_d;
         st_wea_q    <= st_wea_d;
         st_addr_q   <= st_addr_d;
         st_dina_q   <= st_dina_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         cycle_q     <= cycle_d;
      end
   end

   qea_res_reg #(.WIDTH(WORD_W)) u_res_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (res_load),
      .data_i  (i_qea_state_dout),
      .last_i  (res_last),
      .ready_i (i_res_ready),
      .valid_o (o_res_valid),
      .data_o  (o_res_data),
      .last_o  (o_res_last)
   );

   assign o_ctx_ready       = ctx_ready_q;
   assign o_qea_start       = start_q;
   assign o_qea_qbit_num    = qbit_q;
   assign o_qea_ctx_en      = ctx_en_q;
   assign o_qea_ctx_wea     = ctx_wea_q;
   assign o_qea_ctx_addr    = ctx_addr_q;
   assign o_qea_ctx_data    = ctx_data_q;
   assign o_qea_state_ena   = st_ena_q;
   assign o_qea_state_wea   = st_wea_q;
   assign o_qea_state_addra = st_addr_q;
   assign o_qea_state_dina  = st_dina_q;
   assign o_busy            = busy_q;
   assign o_done            = done_q;
   assign o_err             = err_q;
   assign o_cycle_count     = cycle_q;

endmodule
